// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage interlock/forwarding controller with a memory-wait freeze FSM.
// Optional statistics counters are enabled by defining PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic [4:0]        ern0,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [4:0]        mrn,
  input  logic              dmem_ready,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              wpcir,
  output logic              dbubble,
  output logic              pstall,
  output logic              mem_err,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] luse_cnt,
  output logic [STAT_W-1:0] mwait_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_MWAIT = 2'b01,
    ST_ERR   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             luse_s;
  logic             macc_s;
  logic             mwait_start_s;

  // E-stage ALU result wins over M-stage; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       e_wr,
                                         input logic       e_ld,
                                         input logic [4:0] e_rn,
                                         input logic       m_wr,
                                         input logic       m_ld,
                                         input logic [4:0] m_rn);
    logic [1:0] sel;
    if (e_wr && !e_ld && (e_rn != 5'd0) && (e_rn == src)) begin
      sel = 2'b01;
    end else if (m_wr && (m_rn != 5'd0) && (m_rn == src)) begin
      sel = m_ld ? 2'b11 : 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding selects
  always_comb begin
    fwda   = fwd_sel(rs, ewreg, em2reg, ern0, mwreg, mm2reg, mrn);
    fwdb   = fwd_sel(rt, ewreg, em2reg, ern0, mwreg, mm2reg, mrn);
    macc_s = mm2reg | mwmem;
    luse_s = ewreg & em2reg & (ern0 != 5'd0) &
             ((use_rs & (ern0 == rs)) | (use_rt & (ern0 == rt)));
    mwait_start_s = (state_q == ST_RUN) & macc_s & ~dmem_ready;
  end

  // Pipeline control outputs decoded from the current state
  always_comb begin
    wpcir   = 1'b0;
    dbubble = 1'b0;
    pstall  = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (macc_s && !dmem_ready) begin
          wpcir   = 1'b0;
          dbubble = 1'b0;
          pstall  = 1'b1;
        end else if (luse_s) begin
          wpcir   = 1'b0;
          dbubble = 1'b1;
          pstall  = 1'b0;
        end else begin
          wpcir   = 1'b1;
          dbubble = 1'b0;
          pstall  = 1'b0;
        end
      end
      ST_MWAIT: begin
        wpcir   = 1'b0;
        dbubble = 1'b0;
        pstall  = 1'b1;
      end
      ST_ERR: begin
        wpcir   = 1'b0;
        dbubble = 1'b1;
        pstall  = 1'b1;
      end
      default: begin
        wpcir   = 1'b0;
        dbubble = 1'b1;
        pstall  = 1'b1;
      end
    endcase
  end

  // Next-state, wait counter and sticky error computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (macc_s && !dmem_ready) begin
          state_d = ST_MWAIT;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MWAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // FSM state, wait counter and error flag registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state   = state_q;
  assign mem_err = err_q;

`ifdef PIPE_HAZARD_STATS_EN
  logic [STAT_W-1:0] luse_cnt_q, luse_cnt_d;
  logic [STAT_W-1:0] mwait_cnt_q, mwait_cnt_d;

  // Saturating statistics counter updates
  always_comb begin
    luse_cnt_d  = luse_cnt_q;
    mwait_cnt_d = mwait_cnt_q;
    if ((state_q == ST_RUN) && luse_s && !mwait_start_s &&
        (luse_cnt_q != {STAT_W{1'b1}})) begin
      luse_cnt_d = luse_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      luse_cnt_d = luse_cnt_q;
    end
    if ((state_q == ST_MWAIT) && (mwait_cnt_q != {STAT_W{1'b1}})) begin
      mwait_cnt_d = mwait_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      mwait_cnt_d = mwait_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      luse_cnt_q  <= {STAT_W{1'b0}};
      mwait_cnt_q <= {STAT_W{1'b0}};
    end else begin
      luse_cnt_q  <= luse_cnt_d;
      mwait_cnt_q <= mwait_cnt_d;
    end
  end

  assign luse_cnt  = luse_cnt_q;
  assign mwait_cnt = mwait_cnt_q;
`else
  assign luse_cnt  = {STAT_W{1'b0}};
  assign mwait_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences
// (memory wait, timeout, counter saturation) with an expected-value queue.
module tb_pipe_hazard_ctrl;

  localparam int STAT_W = 4;

  logic              clock = 1'b0;
  logic              resetn;
  logic [4:0]        rs, rt, ern0, mrn;
  logic              use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, mwmem, dmem_ready;
  logic [1:0]        fwda, fwdb, state;
  logic              wpcir, dbubble, pstall, mem_err;
  logic [STAT_W-1:0] luse_cnt, mwait_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8), .STAT_W(STAT_W)) dut (
    .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .ern0(ern0), .mwreg(mwreg), .mm2reg(mm2reg),
    .mwmem(mwmem), .mrn(mrn), .dmem_ready(dmem_ready), .fwda(fwda), .fwdb(fwdb),
    .wpcir(wpcir), .dbubble(dbubble), .pstall(pstall), .mem_err(mem_err), .state(state),
    .luse_cnt(luse_cnt), .mwait_cnt(mwait_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs, rt, ern0, mrn;
    logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, mwmem, rdy;
    logic [1:0] fwda, fwdb, state;
    logic       wpcir, dbubble, pstall, mem_err;
  } vec_t;

  typedef struct {
    logic [1:0] fwda, fwdb, state;
    logic       wpcir, dbubble, pstall, mem_err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    rs = v.rs; rt = v.rt; ern0 = v.ern0; mrn = v.mrn;
    use_rs = v.use_rs; use_rt = v.use_rt; ewreg = v.ewreg; em2reg = v.em2reg;
    mwreg = v.mwreg; mm2reg = v.mm2reg; mwmem = v.mwmem; dmem_ready = v.rdy;
  endtask

  // Push expectation, compare at the falling edge, then advance one clock.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    e.fwda = v.fwda; e.fwdb = v.fwdb; e.state = v.state; e.wpcir = v.wpcir;
    e.dbubble = v.dbubble; e.pstall = v.pstall; e.mem_err = v.mem_err;
    drive(v);
    exp_q.push_back(e);
    @(negedge clock);
    e = exp_q.pop_front();
    check({tag, ".fwda"},    {14'd0, fwda},    {14'd0, e.fwda});
    check({tag, ".fwdb"},    {14'd0, fwdb},    {14'd0, e.fwdb});
    check({tag, ".state"},   {14'd0, state},   {14'd0, e.state});
    check({tag, ".wpcir"},   {15'd0, wpcir},   {15'd0, e.wpcir});
    check({tag, ".dbubble"}, {15'd0, dbubble}, {15'd0, e.dbubble});
    check({tag, ".pstall"},  {15'd0, pstall},  {15'd0, e.pstall});
    check({tag, ".mem_err"}, {15'd0, mem_err}, {15'd0, e.mem_err});
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] rs_i, rt_i, input logic urs, urt,
                              input logic ew, em, input logic [4:0] ern,
                              input logic mw, mm, mwm, input logic [4:0] mr, input logic rdy,
                              input logic [1:0] fa, fb, input logic wp, db, ps,
                              input logic [1:0] st, input logic er);
    vec_t v;
    v.rs = rs_i; v.rt = rt_i; v.use_rs = urs; v.use_rt = urt; v.ewreg = ew; v.em2reg = em;
    v.ern0 = ern; v.mwreg = mw; v.mm2reg = mm; v.mwmem = mwm; v.mrn = mr; v.rdy = rdy;
    v.fwda = fa; v.fwdb = fb; v.wpcir = wp; v.dbubble = db; v.pstall = ps;
    v.state = st; v.mem_err = er;
    return v;
  endfunction

  task automatic do_reset();
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,
             2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [STAT_W-1:0] exp_luse, exp_mwait;
    //             rs     rt     urs   urt   ew    em    ern0   mw    mm    mwm   mrn    rdy   fa     fb     wp    db    ps    st     err
    vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[1]  = mk(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[2]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[3]  = mk(5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[4]  = mk(5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[5]  = mk(5'd6, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[6]  = mk(5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    vecs[7]  = mk(5'd1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[8]  = mk(5'd1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[9]  = mk(5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    vecs[10] = mk(5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    do_reset();
    check("rst.luse_cnt",  {12'd0, luse_cnt},  16'd0);
    check("rst.mwait_cnt", {12'd0, mwait_cnt}, 16'd0);
    for (int i = 0; i < 11; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Memory wait overlapping a load-use: freeze first, bubble after release.
    do_reset();
    v = mk(5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0,
           2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    step("mw0", v);
    v.state = 2'b01;
    step("mw1", v);
    step("mw2", v);
    v.rdy = 1'b1;
    step("mw3", v);
    v.state = 2'b00; v.dbubble = 1'b1; v.pstall = 1'b0;
    step("mw4", v);
`ifdef PIPE_HAZARD_STATS_EN
    exp_luse = 4'd1; exp_mwait = 4'd3;
`else
    exp_luse = 4'd0; exp_mwait = 4'd0;
`endif
    @(negedge clock);
    check("mw.luse_cnt",  {12'd0, luse_cnt},  {12'd0, exp_luse});
    check("mw.mwait_cnt", {12'd0, mwait_cnt}, {12'd0, exp_mwait});
    @(posedge clock);
    #1;

    // Timeout with MEM_TIMEOUT=4: one RUN cycle, four MWAIT cycles, then ERR.
    do_reset();
    v = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0,
           2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    step("to_run", v);
    v.state = 2'b01;
    for (int i = 1; i <= 4; i++) step($sformatf("to_wait%0d", i), v);
    v.state = 2'b10; v.mem_err = 1'b1; v.dbubble = 1'b1;
    step("to_err0", v);
    v.rdy = 1'b1;
    step("to_err1", v);
    step("to_err2", v);
`ifdef PIPE_HAZARD_STATS_EN
    exp_mwait = 4'd4;
`else
    exp_mwait = 4'd0;
`endif
    check("to.mwait_cnt", {12'd0, mwait_cnt}, {12'd0, exp_mwait});
    #2 resetn = 1'b0;
    #1;
    check("to.rst_state",   {14'd0, state}, 16'd0);
    check("to.rst_mem_err", {15'd0, mem_err}, 16'd0);
    @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock);
    #1;

    // Saturation of the load-use counter over 20 consecutive stalls.
    do_reset();
    for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), vecs[6]);
`ifdef PIPE_HAZARD_STATS_EN
    exp_luse = 4'd15;
`else
    exp_luse = 4'd0;
`endif
    check("sat.luse_cnt",  {12'd0, luse_cnt},  {12'd0, exp_luse});
    check("sat.mwait_cnt", {12'd0, mwait_cnt}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
